// File: rtl/dispatch_pkg.sv
// Shared constants and helpers for the dispatch receiver and its lane compactor.
package dispatch_pkg;

  localparam int DISPATCH_WIDTH_DEF = 3;

  localparam logic [2:0] IQT_INT = 3'b001;
  localparam logic [2:0] IQT_MEM = 3'b010;
  localparam logic [2:0] IQT_FP  = 3'b100;

  localparam int IQT_INT_BIT = 0;
  localparam int IQT_MEM_BIT = 1;
  localparam int IQT_FP_BIT  = 2;

  // Occupancy counter width: must hold 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dispatch_lane_compact.sv
// Prefix popcount over the lane fire vector: per-lane write offset and total fired.
module dispatch_lane_compact #(
  parameter int W     = 3,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]            fire,
  output logic [W-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]        n
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc    = '0;
    offset = '0;
    for (int i = 0; i < W; i++) begin
      offset[i] = acc;
      acc       = acc + CNT_W'(fire[i]);
    end
    n = acc;
  end

endmodule

// File: rtl/dispatch_enq_receiver.sv
// Issue-queue receiver: compacts up to DISPATCH_WIDTH dispatched uops per cycle into an
// in-order circular buffer and drains them one per cycle toward slot allocation.
module dispatch_enq_receiver
  import dispatch_pkg::*;
#(
  parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEF,
  parameter int DEPTH          = 8,
  parameter int UOP_W          = 32,
  parameter int IQ_TYPE_BIT    = IQT_INT_BIT
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [DISPATCH_WIDTH-1:0]             io_dis_uops_valid,
  input  logic [DISPATCH_WIDTH-1:0][2:0]        io_dis_uops_bits_iq_type,
  input  logic [DISPATCH_WIDTH-1:0][UOP_W-1:0]  io_dis_uops_bits_uop,
  output logic [DISPATCH_WIDTH-1:0]             io_dis_uops_ready,
  output logic                                  io_deq_valid,
  output logic [UOP_W-1:0]                      io_deq_bits_uop,
  input  logic                                  io_deq_ready,
  input  logic                                  io_flush,
  output logic [occ_w(DEPTH)-1:0]               io_count,
  output logic                                  io_iq_type_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = occ_w(DEPTH);
  localparam int OFF_W = $clog2(DISPATCH_WIDTH + 1);

  logic [DEPTH-1:0][UOP_W-1:0]          mem;
  logic [PTR_W-1:0]                     head, tail;
  logic [CNT_W-1:0]                     count;
  logic                                 err;

  logic                                 ready;
  logic [DISPATCH_WIDTH-1:0]            fire;
  logic [DISPATCH_WIDTH-1:0]            type_ok;
  logic [DISPATCH_WIDTH-1:0][OFF_W-1:0] offset;
  logic [DISPATCH_WIDTH-1:0][PTR_W-1:0] waddr;
  logic [OFF_W-1:0]                     n;
  logic                                 deq_fire;

  // Ready looks only at registered occupancy so the dispatcher's cross-queue
  // AND of readys never forms a loop back through valid/deq_ready/flush.
  assign ready             = !reset && (count <= CNT_W'(DEPTH - DISPATCH_WIDTH));
  assign io_dis_uops_ready = {DISPATCH_WIDTH{ready}};

  always_comb begin
    type_ok = '0;
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      type_ok[i] = io_dis_uops_bits_iq_type[i][IQ_TYPE_BIT];
  end

  assign fire = io_dis_uops_valid & {DISPATCH_WIDTH{ready}};

  dispatch_lane_compact #(
    .W     (DISPATCH_WIDTH),
    .CNT_W (OFF_W)
  ) u_compact (
    .fire   (fire),
    .offset (offset),
    .n      (n)
  );

  // PTR_W-bit add wraps naturally across the DEPTH-1 -> 0 boundary.
  for (genvar g = 0; g < DISPATCH_WIDTH; g++) begin : g_waddr
    assign waddr[g] = tail + PTR_W'(offset[g]);
  end

  assign io_deq_valid    = !reset && (count != '0);
  assign io_deq_bits_uop = mem[head];
  assign deq_fire        = io_deq_valid && io_deq_ready;
  assign io_count        = count;
  assign io_iq_type_err  = err;

  always_ff @(posedge clock) begin
    for (int i = 0; i < DISPATCH_WIDTH; i++)
      if (fire[i]) mem[waddr[i]] <= io_dis_uops_bits_uop[i];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (|(fire & ~type_ok)) err <= 1'b1;
      if (io_flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        tail  <= tail + PTR_W'(n);
        head  <= head + PTR_W'(deq_fire);
        count <= count + CNT_W'(n) - CNT_W'(deq_fire);
      end
    end
  end

endmodule

// File: tb/tb_dispatch_enq_receiver.sv
// Scoreboard bench: accepted uops are queued in lane order and compared at dequeue.
module tb_dispatch_enq_receiver;
  import dispatch_pkg::*;

  localparam int W     = 3;
  localparam int DEPTH = 8;
  localparam int UOP_W = 32;
  localparam int CW    = occ_w(DEPTH);

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic [W-1:0]              valid = '0;
  logic [W-1:0][2:0]         iq_type = '0;
  logic [W-1:0][UOP_W-1:0]   uop = '0;
  logic [W-1:0]              ready;
  logic                      deq_valid;
  logic [UOP_W-1:0]          deq_uop;
  logic                      deq_ready = 1'b0;
  logic                      flush = 1'b0;
  logic [CW-1:0]             count;
  logic                      err;

  dispatch_enq_receiver #(
    .DISPATCH_WIDTH (W),
    .DEPTH          (DEPTH),
    .UOP_W          (UOP_W),
    .IQ_TYPE_BIT    (IQT_INT_BIT)
  ) dut (
    .clock                    (clock),
    .reset                    (reset),
    .io_dis_uops_valid        (valid),
    .io_dis_uops_bits_iq_type (iq_type),
    .io_dis_uops_bits_uop     (uop),
    .io_dis_uops_ready        (ready),
    .io_deq_valid             (deq_valid),
    .io_deq_bits_uop          (deq_uop),
    .io_deq_ready             (deq_ready),
    .io_flush                 (flush),
    .io_count                 (count),
    .io_iq_type_err           (err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  logic [UOP_W-1:0] sb[$];
  logic             merr = 1'b0;
  logic [UOP_W-1:0] seq  = 32'h100;
  logic [W-1:0][UOP_W-1:0] nu;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_uops();
    for (int i = 0; i < W; i++) begin
      nu[i] = seq;
      seq   = seq + 1;
    end
  endtask

  // Checks post-edge state at negedge, then drives one cycle of stimulus and
  // advances the scoreboard to what the DUT should hold after the next edge.
  task automatic step(input logic [W-1:0] v, input logic [W-1:0] fp,
                      input logic dr, input logic fl);
    logic rdy;
    @(negedge clock);
    rdy = (sb.size() <= DEPTH - W);
    chk("ready", ready, {W{rdy}});
    chk("deq_valid", deq_valid, sb.size() != 0);
    chk("count", count, sb.size());
    chk("err", err, merr);
    valid     = v;
    deq_ready = dr;
    flush     = fl;
    for (int i = 0; i < W; i++) begin
      iq_type[i] = fp[i] ? IQT_FP : IQT_INT;
      uop[i]     = nu[i];
    end
    if (dr && sb.size() != 0) chk("deq_uop", deq_uop, sb.pop_front());
    if (rdy)
      for (int i = 0; i < W; i++)
        if (v[i]) begin
          sb.push_back(nu[i]);
          if (fp[i]) merr = 1'b1;
        end
    if (fl) sb.delete();
  endtask

  task automatic idle(input logic dr);
    next_uops();
    step('0, '0, dr, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    valid = '1;
    deq_ready = 1'b1;
    flush = 1'b0;
    @(negedge clock);
    chk("rst_ready", ready, '0);
    chk("rst_deq_valid", deq_valid, 1'b0);
    reset = 1'b0;
    valid = '0;
    deq_ready = 1'b0;
    sb.delete();
    merr = 1'b0;
  endtask

  initial begin
    nu = '0;
    do_reset();
    idle(1'b0);

    // fill: third all-lane burst is refused at count 6
    repeat (3) begin
      next_uops();
      step(3'b111, 3'b000, 1'b0, 1'b0);
    end
    idle(1'b0);
    chk("fill_count", count, 6);
    chk("fill_ready", ready, '0);
    repeat (6) idle(1'b1);

    // head/tail now at 6: enqueue across the wrap, then enqueue while dequeuing
    next_uops();
    step(3'b111, 3'b000, 1'b1, 1'b0);
    next_uops();
    step(3'b111, 3'b000, 1'b1, 1'b0);
    idle(1'b0);
    chk("wrap_count", count, 5);

    // flush at count 5 with a concurrent enqueue and dequeue
    next_uops();
    step(3'b001, 3'b000, 1'b1, 1'b1);
    idle(1'b0);
    chk("flush_count", count, 0);
    chk("flush_deq_valid", deq_valid, 1'b0);

    // sparse lanes 0 and 2
    nu[0] = 32'hA; nu[1] = 32'hB; nu[2] = 32'hC;
    step(3'b101, 3'b000, 1'b0, 1'b0);
    idle(1'b0);
    chk("sparse_count", count, 2);
    chk("sparse_head", deq_uop, 32'hA);
    repeat (2) idle(1'b1);

    // mis-steer: FP uop still enqueued, err sticky through flush
    next_uops();
    step(3'b010, 3'b010, 1'b0, 1'b0);
    idle(1'b0);
    chk("missteer_err", err, 1'b1);
    chk("missteer_count", count, 1);
    idle(1'b1);
    next_uops();
    step('0, '0, 1'b0, 1'b1);
    idle(1'b0);
    chk("flush_keeps_err", err, 1'b1);
    do_reset();
    idle(1'b0);
    chk("reset_clears_err", err, 1'b0);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      logic [W-1:0] v, fp;
      next_uops();
      v  = W'($urandom);
      fp = '0;
      for (int i = 0; i < W; i++) fp[i] = ($urandom_range(15) == 0);
      step(v, fp, 1'($urandom), $urandom_range(19) == 0);
    end

    // reset mid-operation with traffic applied
    next_uops();
    step(3'b111, 3'b000, 1'b0, 1'b0);
    do_reset();
    idle(1'b0);
    chk("midreset_count", count, 0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
